// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared widths, NOP encoding and FSM state codes for the IF/ID boundary
package if_id_buffer_pkg;

   localparam int IFID_PC_WIDTH   = 32;
   localparam int IFID_INST_WIDTH = 32;

   // addi x0, x0, 0
   localparam logic [31:0] IFID_NOP_INST = 32'h0000_0013;

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] KILL = 2'd2;

endpackage

// File: rtl/if_id_buffer_skid.sv
// rtl/if_id_buffer_skid.sv - one-entry {pc, inst} holding register with load/clear/full
module skid_reg #(
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  clr,
   input  logic [PC_WIDTH-1:0]   pc_d,
   input  logic [INST_WIDTH-1:0] inst_d,
   output logic [PC_WIDTH-1:0]   pc_q,
   output logic [INST_WIDTH-1:0] inst_q,
   output logic                  full
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         inst_q <= '0;
         full   <= 1'b0;
      end else if (clr) begin
         pc_q   <= '0;
         inst_q <= '0;
         full   <= 1'b0;
      end else if (load) begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
         full   <= 1'b1;
      end
   end

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - fetch/decode boundary register with stall skid and post-jump kill window
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int                    PC_WIDTH    = IFID_PC_WIDTH,
   parameter int                    INST_WIDTH  = IFID_INST_WIDTH,
   parameter int                    KILL_CYCLES = 1,
   parameter logic [INST_WIDTH-1:0] NOP_INST    = IFID_NOP_INST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  work_ena,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [PC_WIDTH-1:0]   pc_i,
   input  logic [INST_WIDTH-1:0] inst_i,
   output logic [PC_WIDTH-1:0]   pc_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic                  valid_o,
   output logic                  skid_full_o
);

   logic [1:0]            state, state_nxt;
   logic [1:0]            kill_cnt, kill_nxt;
   logic [PC_WIDTH-1:0]   pc_nxt;
   logic [INST_WIDTH-1:0] inst_nxt;
   logic                  valid_nxt;
   logic                  skid_load, skid_clr;
   logic [PC_WIDTH-1:0]   skid_pc;
   logic [INST_WIDTH-1:0] skid_inst;
   logic                  skid_full;
   logic                  in_ok;
   logic                  new_fetch;

   assign in_ok = work_ena & ~flush & (kill_cnt == 2'd0);
   // upstream repeats the stalled PC; only a different PC is a new fetch
   assign new_fetch = in_ok & (pc_i != skid_pc);

   skid_reg #(
      .PC_WIDTH   (PC_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .clr    (skid_clr),
      .pc_d   (pc_i),
      .inst_d (inst_i),
      .pc_q   (skid_pc),
      .inst_q (skid_inst),
      .full   (skid_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         kill_cnt <= 2'd0;
         pc_o     <= '0;
         inst_o   <= NOP_INST;
         valid_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         kill_cnt <= kill_nxt;
         pc_o     <= pc_nxt;
         inst_o   <= inst_nxt;
         valid_o  <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      kill_nxt  = kill_cnt;
      if (!work_ena) begin
         state_nxt = RUN;
         kill_nxt  = 2'd0;
      end else if (flush) begin
         kill_nxt  = 2'(KILL_CYCLES);
         state_nxt = (KILL_CYCLES == 0) ? RUN : KILL;
      end else begin
         case (state)
            KILL: begin
               if (kill_cnt <= 2'd1) begin
                  kill_nxt  = 2'd0;
                  state_nxt = RUN;
               end else begin
                  kill_nxt = 2'(kill_cnt - 2'd1);
               end
            end
            RUN:     if (stall && in_ok) state_nxt = HOLD;
            HOLD:    if (!stall && !new_fetch) state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      pc_nxt    = pc_o;
      inst_nxt  = inst_o;
      valid_nxt = valid_o;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      if (!work_ena) begin
         pc_nxt    = '0;
         inst_nxt  = NOP_INST;
         valid_nxt = 1'b0;
         skid_clr  = 1'b1;
      end else if (flush) begin
         inst_nxt  = NOP_INST;
         valid_nxt = 1'b0;
         skid_clr  = 1'b1;
      end else begin
         case (state)
            KILL: begin
               if (!stall) begin
                  inst_nxt  = NOP_INST;
                  valid_nxt = 1'b0;
               end
            end
            RUN: begin
               if (!stall) begin
                  pc_nxt    = pc_i;
                  inst_nxt  = in_ok ? inst_i : NOP_INST;
                  valid_nxt = in_ok;
               end else if (in_ok) begin
                  skid_load = 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc_nxt    = skid_pc;
                  inst_nxt  = skid_inst;
                  valid_nxt = 1'b1;
                  skid_load = new_fetch;
                  skid_clr  = ~new_fetch;
               end
            end
            default: ;
         endcase
      end
   end

   assign skid_full_o = skid_full;

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - randomized scoreboard bench for the IF/ID boundary register
module tb_if_id_buffer;
   localparam int          KC  = 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk, rst_n, work_ena, stall, flush;
   logic [31:0] pc_i, inst_i, pc_o, inst_o;
   logic        valid_o, skid_full_o;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } pair_t;

   pair_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          kill_left = 0;
   bit          last_vld = 0;
   logic [31:0] last_pc = '0;
   logic [31:0] cur_pc = '0, cur_inst = '0, next_base = 32'h0010_0000;
   logic [31:0] pres_pc, pres_inst, b_inst, c_inst;

   if_id_buffer #(.KILL_CYCLES(KC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .work_ena    (work_ena),
      .stall       (stall),
      .flush       (flush),
      .pc_i        (pc_i),
      .inst_i      (inst_i),
      .pc_o        (pc_o),
      .inst_o      (inst_o),
      .valid_o     (valid_o),
      .skid_full_o (skid_full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic new_region();
      cur_pc    = next_base;
      cur_inst  = $urandom;
      next_base = next_base + 32'h0001_0000;
   endtask

   task automatic set_up(input logic [31:0] pc);
      cur_pc   = pc;
      cur_inst = $urandom;
   endtask

   // Reference: every distinct fetch accepted while not killed is delivered once, in order;
   // a flush or disable discards everything still pending.
   task automatic drive(input bit we, input bit st, input bit fl);
      @(negedge clk);
      #1;
      work_ena  = we;
      stall     = st;
      flush     = fl;
      pc_i      = cur_pc;
      inst_i    = cur_inst;
      pres_pc   = cur_pc;
      pres_inst = cur_inst;
      if (!we) begin
         exp_q.delete();
         kill_left = 0;
         last_vld  = 0;
      end else if (fl) begin
         exp_q.delete();
         kill_left = KC;
         last_vld  = 0;
      end else if (kill_left > 0) begin
         kill_left--;
      end else if (!(last_vld && last_pc == cur_pc)) begin
         exp_q.push_back('{pc: cur_pc, inst: cur_inst});
         last_vld = 1;
         last_pc  = cur_pc;
      end
      if (!we || fl) new_region();
      else if (!st) begin
         cur_pc   = cur_pc + 32'd4;
         cur_inst = $urandom;
      end
   endtask

   task automatic step(input bit we, input bit st, input bit fl);
      drive(we, st, fl);
      @(posedge clk);
      #1;
   endtask

   // Decode consumes the presented pair on any edge where it is valid and not stalled or flushed.
   initial begin
      pair_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!valid_o) chk("nop_when_invalid", inst_o, NOP);
         if (rst_n === 1'b1 && work_ena && !flush && !stall && valid_o) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL sb_unexpected got pc %h with no pending fetch", pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", pc_o, e.pc);
               chk("sb_inst", inst_o, e.inst);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; work_ena = 1'b0; stall = 1'b0; flush = 1'b0;
      pc_i = '0; inst_i = '0;
      #7;
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_skid", {31'b0, skid_full_o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // sequential fetch, then a 3-cycle stall over 0x08
      set_up(32'h0);
      step(1, 0, 0);
      chk("t1_pc0", pc_o, 32'h00);
      chk("t1_v0", {31'b0, valid_o}, 32'h1);
      step(1, 0, 0);
      b_inst = pres_inst;
      chk("t1_pc4", pc_o, 32'h04);
      step(1, 1, 0);
      c_inst = pres_inst;
      chk("t2_hold_pc", pc_o, 32'h04);
      chk("t2_hold_inst", inst_o, b_inst);
      chk("t2_skid", {31'b0, skid_full_o}, 32'h1);
      step(1, 1, 0);
      step(1, 1, 0);
      chk("t2_still_pc", pc_o, 32'h04);
      step(1, 0, 0);
      chk("t2_rel_pc", pc_o, 32'h08);
      chk("t2_rel_inst", inst_o, c_inst);
      chk("t2_rel_skid", {31'b0, skid_full_o}, 32'h0);
      step(1, 0, 0);
      chk("t2_next_pc", pc_o, 32'h0C);
      chk("t2_next_v", {31'b0, valid_o}, 32'h1);

      // flush with one kill cycle, target 0x40 presented at t+2
      step(1, 0, 1);
      chk("t3_v_t1", {31'b0, valid_o}, 32'h0);
      step(1, 0, 0);
      chk("t3_v_t2", {31'b0, valid_o}, 32'h0);
      set_up(32'h40);
      step(1, 0, 0);
      chk("t3_v_t3", {31'b0, valid_o}, 32'h1);
      chk("t3_pc_t3", pc_o, 32'h40);

      // flush and stall together while holding
      step(1, 1, 0);
      chk("t4_skid_in", {31'b0, skid_full_o}, 32'h1);
      step(1, 1, 1);
      chk("t4_skid_out", {31'b0, skid_full_o}, 32'h0);
      chk("t4_valid", {31'b0, valid_o}, 32'h0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);

      // work_ena drop mid-stream
      step(0, 0, 0);
      chk("t5_pc", pc_o, 32'h0);
      chk("t5_inst", inst_o, NOP);
      chk("t5_valid", {31'b0, valid_o}, 32'h0);

      // asynchronous reset while holding
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      chk("t6_skid_in", {31'b0, skid_full_o}, 32'h1);
      @(negedge clk);
      #2;
      work_ena = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("t6_pc", pc_o, 32'h0);
      chk("t6_inst", inst_o, NOP);
      chk("t6_valid", {31'b0, valid_o}, 32'h0);
      chk("t6_skid", {31'b0, skid_full_o}, 32'h0);
      exp_q.delete();
      kill_left = 0;
      last_vld  = 0;
      new_region();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4);
      end
      step(1, 0, 0);
      step(1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
